// File: rtl/irq_ctrl.sv
// Multi-channel interrupt controller: per-channel synchroniser, edge/level capture,
// fixed-priority arbitration (lowest index wins) and claim/complete service tracking.
// Define IRQ_CTRL_OVERFLOW_EN to add sticky per-channel overflow flags.
module irq_ctrl #(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] mode,
    input  logic [NUM_IRQ-1:0] enable,
    input  logic               claim,
    input  logic               complete,
    input  logic [ID_W-1:0]    complete_id,
`ifdef IRQ_CTRL_OVERFLOW_EN
    output logic [NUM_IRQ-1:0] overflow,
    input  logic [NUM_IRQ-1:0] ovf_clear,
`endif
    output logic               irq_out,
    output logic [ID_W-1:0]    claim_id,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] in_service
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_SERV = 2'd2;

    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] r_sync;
    logic [NUM_IRQ-1:0]                  r_prev;
    logic [NUM_IRQ-1:0][1:0]             r_state;
    logic [NUM_IRQ-1:0]                  r_requeue;

    logic [NUM_IRQ-1:0]      w_irq_s;
    logic [NUM_IRQ-1:0]      w_edge;
    logic [NUM_IRQ-1:0]      w_edge_m;
    logic [NUM_IRQ-1:0]      w_pend;
    logic [NUM_IRQ-1:0]      w_elig;
    logic                    w_irq_out;
    logic [ID_W-1:0]         w_claim_id;
    logic [NUM_IRQ-1:0]      w_claim_hit;
    logic [NUM_IRQ-1:0]      w_cpl_hit;
    logic [NUM_IRQ-1:0][1:0] w_state_nxt;
    logic [NUM_IRQ-1:0]      w_requeue_nxt;

    assign w_irq_s  = r_sync[SYNC_STAGES-1];
    assign w_edge   = w_irq_s & ~r_prev;
    assign w_edge_m = w_edge & mode;

    // State register: synchronisers, edge history, channel state and requeue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync    <= '0;
            r_prev    <= '0;
            r_state   <= '0;
            r_requeue <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            r_sync    <= {r_sync[SYNC_STAGES-2:0], irq};
            r_prev    <= w_irq_s;
            r_state   <= w_state_nxt;
            r_requeue <= w_requeue_nxt;
        end
    end

    // Fixed-priority arbitration over enabled pending channels; the lowest index wins.
    always_comb begin
        w_claim_id = '0;
        for (int ch = NUM_IRQ - 1; ch >= 0; ch--) begin
            if (w_elig[ch]) begin
                w_claim_id = ID_W'(ch);
            end
        end
    end

    assign w_irq_out = |w_elig;

    always_comb begin
        w_claim_hit = '0;
        w_cpl_hit   = '0;
        for (int ch = 0; ch < NUM_IRQ; ch++) begin
            w_claim_hit[ch] = claim && w_irq_out && (w_claim_id == ID_W'(ch));
            w_cpl_hit[ch]   = complete && (complete_id == ID_W'(ch));
        end
    end

    // Next-state logic per channel.
    always_comb begin
        // NOTE: defaults first so no path leaves a combinational variable unassigned (no latch).
        w_state_nxt   = r_state;
        w_requeue_nxt = r_requeue;
        for (int ch = 0; ch < NUM_IRQ; ch++) begin
            case (r_state[ch])
                ST_IDLE: begin
                    if (mode[ch] ? w_edge[ch] : w_irq_s[ch]) begin
                        w_state_nxt[ch] = ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (w_claim_hit[ch]) begin
                        w_state_nxt[ch] = ST_SERV;
                    end
                end
                ST_SERV: begin
                    // An edge coinciding with complete counts as an already-latched requeue.
                    if (w_cpl_hit[ch]) begin
                        w_state_nxt[ch]   = (r_requeue[ch] || w_edge_m[ch]) ? ST_PEND : ST_IDLE;
                        w_requeue_nxt[ch] = 1'b0;
                    end else if (w_edge_m[ch]) begin
                        w_requeue_nxt[ch] = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt[ch]   = ST_IDLE;
                    w_requeue_nxt[ch] = 1'b0;
                end
            endcase
        end
    end

    // Output decode from registered state.
    always_comb begin
        w_pend     = '0;
        in_service = '0;
        for (int ch = 0; ch < NUM_IRQ; ch++) begin
            w_pend[ch]     = (r_state[ch] == ST_PEND);
            in_service[ch] = (r_state[ch] == ST_SERV);
        end
    end

    assign w_elig   = w_pend & enable;
    assign pending  = w_pend;
    assign irq_out  = w_irq_out;
    assign claim_id = w_claim_id;

`ifdef IRQ_CTRL_OVERFLOW_EN
    logic [NUM_IRQ-1:0] r_overflow;
    logic [NUM_IRQ-1:0] w_ovf_set;

    // An edge lost to coalescing: already pending, or already requeued while in service.
    assign w_ovf_set = w_edge_m & (w_pend | (in_service & r_requeue));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= '0;
        end else begin
            r_overflow <= (r_overflow & ~ovf_clear) | w_ovf_set;
        end
    end

    assign overflow = r_overflow;
`endif

endmodule
